// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline buffers: holding-state encoding
// and the occupancy value reported for each state.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   function automatic logic [1:0] occ_of(input state_t s);
      case (s)
         ONE:     occ_of = OCC_ONE;
         FULL:    occ_of = OCC_FULL;
         default: occ_of = OCC_EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/pipe_entry.sv
// One buffer slot: a data+ctrl register with load enable, cleared by async reset.
module pipe_entry #(
   parameter int WIDTH = 72
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline buffer with valid/ready handshake, flush, ctrl bubble
// gating, optional 2-entry skid mode, occupancy and saturating stall counter.
module pipe_stage_buffer
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = 8,
   parameter bit SKID_EN         = 1'b1,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic [CTRL_WIDTH-1:0]      in_ctrl,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [CTRL_WIDTH-1:0]      out_ctrl,
   output logic [1:0]                 occupancy,
   output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

   localparam int EW = DATA_WIDTH + CTRL_WIDTH;

   state_t          state;
   state_t          state_nxt;
   logic            accept;
   logic            drain;
   logic            main_load;
   logic            skid_load;
   logic [EW-1:0]   in_entry;
   logic [EW-1:0]   main_d;
   logic [EW-1:0]   main_q;
   logic [EW-1:0]   skid_q;

   assign in_entry  = {in_data, in_ctrl};
   assign out_valid = (state != EMPTY);
   assign occupancy = occ_of(state);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   // Skid mode decodes in_ready from state alone, cutting the out_ready path.
   generate
      if (SKID_EN) begin : g_rdy_skid
         assign in_ready = (state != FULL);
      end else begin : g_rdy_comb
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = in_entry;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               main_load = 1'b1;
            end
         end
         ONE: begin
            if (accept && drain) begin
               main_load = 1'b1;
            end else if (accept) begin
               if (SKID_EN) begin
                  state_nxt = FULL;
                  skid_load = 1'b1;
               end
            end else if (drain) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               state_nxt = ONE;
               main_load = 1'b1;
               main_d    = skid_q;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      if (flush) begin
         state_nxt = EMPTY;
         main_load = 1'b0;
         skid_load = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   pipe_entry #(.WIDTH(EW)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_load),
      .d     (main_d),
      .q     (main_q)
   );

   generate
      if (SKID_EN) begin : g_skid
         pipe_entry #(.WIDTH(EW)) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (skid_load),
            .d     (in_entry),
            .q     (skid_q)
         );
      end else begin : g_no_skid
         assign skid_q = '0;
      end
   endgenerate

   assign out_data = main_q[EW-1:CTRL_WIDTH];
   assign out_ctrl = out_valid ? main_q[CTRL_WIDTH-1:0] : '0;

   // Counter survives flush so stalls around a flush stay visible.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: skid instance (4-bit stall counter) and
// single-entry instance, checked against a queue-based reference model.
module tb_pipe_stage_buffer;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  ctrl;
   } ent_t;

   typedef struct {
      logic        iv;
      logic [63:0] data;
      logic [7:0]  ctrl;
      logic        ordy;
      logic        fl;
      logic        exp_rdy;
      logic        exp_vld;
      logic [63:0] exp_data;
      logic [7:0]  exp_ctrl;
      logic [1:0]  exp_occ;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        a_fl = 0, a_iv = 0, a_ordy = 0;
   logic [63:0] a_data = '0;
   logic [7:0]  a_ctrl = '0;
   logic        a_rdy, a_vld;
   logic [63:0] a_odata;
   logic [7:0]  a_octrl;
   logic [1:0]  a_occ;
   logic [3:0]  a_stall;

   logic        b_fl = 0, b_iv = 0, b_ordy = 0;
   logic [63:0] b_data = '0;
   logic [7:0]  b_ctrl = '0;
   logic        b_rdy, b_vld;
   logic [63:0] b_odata;
   logic [7:0]  b_octrl;
   logic [1:0]  b_occ;
   logic [15:0] b_stall;

   pipe_stage_buffer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .SKID_EN(1'b1), .STALL_CNT_WIDTH(4)) dut_a (
      .clk(clk), .reset(reset), .flush(a_fl), .in_valid(a_iv), .in_ready(a_rdy),
      .in_data(a_data), .in_ctrl(a_ctrl), .out_valid(a_vld), .out_ready(a_ordy),
      .out_data(a_odata), .out_ctrl(a_octrl), .occupancy(a_occ), .stall_cycles(a_stall)
   );

   pipe_stage_buffer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .SKID_EN(1'b0), .STALL_CNT_WIDTH(16)) dut_b (
      .clk(clk), .reset(reset), .flush(b_fl), .in_valid(b_iv), .in_ready(b_rdy),
      .in_data(b_data), .in_ctrl(b_ctrl), .out_valid(b_vld), .out_ready(b_ordy),
      .out_data(b_odata), .out_ctrl(b_octrl), .occupancy(b_occ), .stall_cycles(b_stall)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   ent_t qa[$];
   ent_t qb[$];
   int   stall_a = 0;
   int   stall_b = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      chk("a_in_ready", 64'(a_rdy), 64'(qa.size() < 2));
      chk("a_out_valid", 64'(a_vld), 64'(qa.size() > 0));
      chk("a_occupancy", 64'(a_occ), 64'(qa.size()));
      chk("a_out_ctrl", 64'(a_octrl), (qa.size() > 0) ? 64'(qa[0].ctrl) : 64'd0);
      if (qa.size() > 0) chk("a_out_data", a_odata, qa[0].data);
      chk("a_stall", 64'(a_stall), 64'(stall_a));
      chk("b_in_ready", 64'(b_rdy), 64'((qb.size() == 0) || b_ordy));
      chk("b_out_valid", 64'(b_vld), 64'(qb.size() > 0));
      chk("b_occupancy", 64'(b_occ), 64'(qb.size()));
      chk("b_out_ctrl", 64'(b_octrl), (qb.size() > 0) ? 64'(qb[0].ctrl) : 64'd0);
      if (qb.size() > 0) chk("b_out_data", b_odata, qb[0].data);
      chk("b_stall", 64'(b_stall), 64'(stall_b));
   endtask

   // One clock: check at the falling edge, then advance the model at the rising edge.
   task automatic step();
      bit   a_take, a_pop, b_take, b_pop;
      ent_t e;
      @(negedge clk);
      model_check();
      a_take = a_iv && (qa.size() < 2);
      a_pop  = a_ordy && (qa.size() > 0);
      b_take = b_iv && ((qb.size() == 0) || b_ordy);
      b_pop  = b_ordy && (qb.size() > 0);
      @(posedge clk);
      if (reset) begin
         qa.delete(); qb.delete(); stall_a = 0; stall_b = 0;
      end else begin
         if (qa.size() > 0 && !a_ordy && stall_a < 15) stall_a++;
         if (qb.size() > 0 && !b_ordy && stall_b < 65535) stall_b++;
         if (a_fl) qa.delete();
         else begin
            if (a_pop) void'(qa.pop_front());
            if (a_take) begin e.data = a_data; e.ctrl = a_ctrl; qa.push_back(e); end
         end
         if (b_fl) qb.delete();
         else begin
            if (b_pop) void'(qb.pop_front());
            if (b_take) begin e.data = b_data; e.ctrl = b_ctrl; qb.push_back(e); end
         end
      end
      #1;
   endtask

   task automatic async_reset();
      reset = 1'b1;
      #1;
      qa.delete(); qb.delete(); stall_a = 0; stall_b = 0;
      chk("rst_a_occ", 64'(a_occ), 64'd0);
      chk("rst_a_vld", 64'(a_vld), 64'd0);
      chk("rst_a_ctrl", 64'(a_octrl), 64'd0);
      chk("rst_a_stall", 64'(a_stall), 64'd0);
      step();
      reset = 1'b0;
      step();
   endtask

   vec_t vecs[7];

   initial begin
      // Reset held with an input presented.
      a_iv = 1; a_data = 64'hAA; a_ctrl = 8'hFF; b_iv = 1; b_data = 64'hAA; b_ctrl = 8'hFF;
      #2;
      chk("rst_hold_a_rdy", 64'(a_rdy), 64'd1);
      chk("rst_hold_a_occ", 64'(a_occ), 64'd0);
      chk("rst_hold_a_data", a_odata, 64'd0);
      step(); step();
      reset = 1'b0;
      a_iv = 0; b_iv = 0;
      step();
      chk("post_rst_a_vld", 64'(a_vld), 64'd0);
      chk("post_rst_a_ctrl", 64'(a_octrl), 64'd0);
      chk("post_rst_b_rdy", 64'(b_rdy), 64'd1);

      // Fill to FULL with out_ready low, then drain in order.
      vecs[0] = '{1, 64'h11, 8'h81, 0, 0, 1, 0, 64'h0,  8'h00, 2'd0};
      vecs[1] = '{1, 64'h22, 8'h42, 0, 0, 1, 1, 64'h11, 8'h81, 2'd1};
      vecs[2] = '{1, 64'h33, 8'h24, 0, 0, 0, 1, 64'h11, 8'h81, 2'd2};
      vecs[3] = '{1, 64'h33, 8'h24, 1, 0, 0, 1, 64'h11, 8'h81, 2'd2};
      vecs[4] = '{1, 64'h33, 8'h24, 1, 0, 1, 1, 64'h22, 8'h42, 2'd1};
      vecs[5] = '{0, 64'h00, 8'h00, 1, 0, 1, 1, 64'h33, 8'h24, 2'd1};
      vecs[6] = '{0, 64'h00, 8'h00, 0, 0, 1, 0, 64'h0,  8'h00, 2'd0};
      foreach (vecs[i]) begin
         a_iv = vecs[i].iv; a_data = vecs[i].data; a_ctrl = vecs[i].ctrl;
         a_ordy = vecs[i].ordy; a_fl = vecs[i].fl;
         #1;
         chk("tbl_rdy", 64'(a_rdy), 64'(vecs[i].exp_rdy));
         chk("tbl_vld", 64'(a_vld), 64'(vecs[i].exp_vld));
         chk("tbl_ctrl", 64'(a_octrl), 64'(vecs[i].exp_ctrl));
         chk("tbl_occ", 64'(a_occ), 64'(vecs[i].exp_occ));
         if (vecs[i].exp_vld) chk("tbl_data", a_odata, vecs[i].exp_data);
         step();
      end

      // Flush while FULL with a concurrent input.
      a_ordy = 0;
      a_iv = 1; a_data = 64'h61; a_ctrl = 8'h11; step();
      a_data = 64'h62; a_ctrl = 8'h12; step();
      a_fl = 1; a_data = 64'h63; a_ctrl = 8'h13; step();
      a_fl = 0; a_iv = 0;
      chk("flush_occ", 64'(a_occ), 64'd0);
      chk("flush_vld", 64'(a_vld), 64'd0);
      chk("flush_ctrl", 64'(a_octrl), 64'd0);
      step();

      // Stall saturation from a clean counter.
      async_reset();
      a_iv = 1; a_data = 64'h77; a_ctrl = 8'h7E; step();
      a_iv = 0;
      for (int i = 0; i < 20; i++) step();
      chk("stall_sat", 64'(a_stall), 64'd15);
      a_fl = 1; step();
      a_fl = 0; step();
      chk("stall_after_flush", 64'(a_stall), 64'd15);

      // Streaming at one per cycle.
      a_ordy = 1;
      for (int i = 0; i < 8; i++) begin
         a_iv = 1; a_data = 64'hA0 + 64'(i); a_ctrl = 8'(i + 1);
         step();
         chk("stream_occ", 64'(a_occ), 64'd1);
         chk("stream_data", a_odata, 64'hA0 + 64'(i));
      end
      a_iv = 0; step();

      // Single-entry mode with toggling out_ready.
      b_iv = 1;
      for (int i = 0; i < 16; i++) begin
         b_ordy = i[0]; b_data = 64'hB0 + 64'(i); b_ctrl = 8'(8'h80 | i);
         step();
      end
      b_iv = 0; b_ordy = 1; step(); step();

      // Mid-operation reset combined with flush.
      a_ordy = 0; a_iv = 1; a_data = 64'hC1; step(); step();
      a_fl = 1; b_fl = 1;
      async_reset();
      a_fl = 0; b_fl = 0; a_iv = 0;
      chk("rst_mid_occ", 64'(a_occ), 64'd0);

      // Randomized traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         a_iv = 1'($urandom_range(0, 1)); a_ordy = 1'($urandom_range(0, 1));
         a_data = {$urandom, $urandom}; a_ctrl = 8'($urandom);
         a_fl = ($urandom_range(0, 31) == 0);
         b_iv = 1'($urandom_range(0, 1)); b_ordy = 1'($urandom_range(0, 1));
         b_data = {$urandom, $urandom}; b_ctrl = 8'($urandom);
         b_fl = ($urandom_range(0, 31) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
